// File: rtl/sa_cache_ctrl_pkg.sv
// Shared types and sizing for the 2-way set-associative cache controller
// and its CPU / SRAM-controller interfaces.
package cache_definition;

  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 16;
  localparam int INDEX_BITS = 6;
  localparam int TAG_BITS   = ADDR_W - INDEX_BITS;
  localparam int NUM_SETS   = 1 << INDEX_BITS;

  typedef struct packed {
    logic              valid;
    logic              rw;     // 1 = write
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cpu_req_type;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] data;
  } cpu_result_type;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cache_to_mem_type;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] data;
  } mem_to_cache_type;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE
  } cache_state_type;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_BITS-1:0] tag;
  } cache_tag_type;

endpackage

// File: rtl/sa_cache_ctrl_way_store.sv
// One cache way: tag/status and data arrays held in flops, read
// asynchronously by set index and written on the clock edge when we is set.
module cache_way_store
  import cache_definition::*;
#(
  parameter int IDX_W  = INDEX_BITS,
  parameter int WORD_W = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  cache_tag_type     tag_in,
  input  logic [WORD_W-1:0] data_in,
  output cache_tag_type     tag_out,
  output logic [WORD_W-1:0] data_out
);

  localparam int SETS = 1 << IDX_W;

  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [WORD_W-1:0]   data_q [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[idx] <= tag_in.valid;
      dirty_q[idx] <= tag_in.dirty;
    end
  end

  // NOTE: tag and data arrays are deliberately left out of reset; the
  // cleared valid bit already makes their contents irrelevant, and keeping
  // reset off large arrays lets them map to plain storage.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[idx]  <= tag_in.tag;
      data_q[idx] <= data_in;
    end
  end

  assign tag_out  = '{valid: valid_q[idx], dirty: dirty_q[idx], tag: tag_q[idx]};
  assign data_out = data_q[idx];

endmodule

// File: rtl/sa_cache_ctrl.sv
// 2-way set-associative write-back / write-allocate cache controller placed
// between a CPU request port and an SRAM controller; one 16-bit word per line.
module sa_cache_ctrl #(
  parameter int INDEX_BITS = cache_definition::INDEX_BITS,
  parameter int ADDR_W     = cache_definition::ADDR_W,
  parameter int DATA_W     = cache_definition::DATA_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  cache_definition::cpu_req_type      cpu_req,
  output cache_definition::cpu_result_type   cpu_res,
  output cache_definition::cache_to_mem_type cache_to_mem,
  input  cache_definition::mem_to_cache_type mem_to_cache
);

  import cache_definition::*;

  localparam int TAG_W = ADDR_W - INDEX_BITS;
  localparam int SETS  = 1 << INDEX_BITS;

  cache_state_type state, state_nxt;

  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [SETS-1:0]   lru_q;     // per set: the way to evict next
  logic              victim_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      req_tag;
  cache_tag_type         tag_rd  [2];
  logic [DATA_W-1:0]     data_rd [2];
  logic [1:0]            we;
  cache_tag_type         tag_wr;
  logic [DATA_W-1:0]     data_wr;

  logic hit0, hit1, hit, hit_way;
  logic victim_sel, victim_dirty;

  assign idx     = req_addr[INDEX_BITS-1:0];
  assign req_tag = req_addr[ADDR_W-1:INDEX_BITS];

  cache_way_store #(.IDX_W(INDEX_BITS), .WORD_W(DATA_W)) u_way0 (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .we       (we[0]),
    .tag_in   (tag_wr),
    .data_in  (data_wr),
    .tag_out  (tag_rd[0]),
    .data_out (data_rd[0])
  );

  cache_way_store #(.IDX_W(INDEX_BITS), .WORD_W(DATA_W)) u_way1 (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .we       (we[1]),
    .tag_in   (tag_wr),
    .data_in  (data_wr),
    .tag_out  (tag_rd[1]),
    .data_out (data_rd[1])
  );

  // Way0 wins a (never expected) double hit; fill invalid ways before using LRU.
  assign hit0         = tag_rd[0].valid && (tag_rd[0].tag == req_tag);
  assign hit1         = tag_rd[1].valid && (tag_rd[1].tag == req_tag);
  assign hit          = hit0 || hit1;
  assign hit_way      = !hit0;
  assign victim_sel   = !tag_rd[0].valid ? 1'b0 :
                        !tag_rd[1].valid ? 1'b1 : lru_q[idx];
  assign victim_dirty = tag_rd[victim_sel].valid && tag_rd[victim_sel].dirty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_rw   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      lru_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      if (state == IDLE && cpu_req.valid) begin
        req_rw   <= cpu_req.rw;
        req_addr <= cpu_req.addr;
        req_data <= cpu_req.data;
      end
      if (state == COMPARE) begin
        if (hit) lru_q[idx] <= ~hit_way;
        else     victim_q   <= victim_sel;
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    we           = '0;
    tag_wr       = '0;
    data_wr      = '0;
    cpu_res      = '0;
    cache_to_mem = '0;

    case (state)
      IDLE: begin
        if (cpu_req.valid) state_nxt = COMPARE;
      end

      COMPARE: begin
        if (hit) begin
          cpu_res.ready = 1'b1;
          if (req_rw) begin
            we[hit_way] = 1'b1;
            tag_wr      = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
            data_wr     = req_data;
          end else begin
            cpu_res.data = data_rd[hit_way];
          end
          state_nxt = IDLE;
        end else if (victim_dirty) begin
          state_nxt = WRITE_BACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end

      WRITE_BACK: begin
        cache_to_mem = '{valid: 1'b1, rw: 1'b1,
                         addr: {tag_rd[victim_q].tag, idx},
                         data: data_rd[victim_q]};
        if (mem_to_cache.ready) begin
          we[victim_q] = 1'b1;
          tag_wr       = '{valid: 1'b1, dirty: 1'b0, tag: tag_rd[victim_q].tag};
          data_wr      = data_rd[victim_q];
          state_nxt    = ALLOCATE;
        end
      end

      ALLOCATE: begin
        cache_to_mem = '{valid: 1'b1, rw: 1'b0, addr: req_addr, data: '0};
        if (mem_to_cache.ready) begin
          // Refill only; a pending write merges on the COMPARE hit that follows.
          we[victim_q] = 1'b1;
          tag_wr       = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          data_wr      = mem_to_cache.data;
          state_nxt    = COMPARE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Directed bench for sa_cache_ctrl with a 1M-word SRAM model that answers
// each request after two cycles of valid.
module tb_sa_cache_ctrl;
  import cache_definition::*;

  localparam int RW_CYCLES = 2;
  localparam int MAX_WAIT  = 200;
  localparam int LAT_HIT   = 1;
  localparam int LAT_CLEAN = 4;

  logic             clk = 1'b0;
  logic             rst;
  cpu_req_type      cpu_req;
  cpu_result_type   cpu_res;
  cache_to_mem_type cache_to_mem;
  mem_to_cache_type mem_to_cache = '0;

  sa_cache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_res      (cpu_res),
    .cache_to_mem (cache_to_mem),
    .mem_to_cache (mem_to_cache)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [19:0] addr;
    logic [15:0] data;
  } txn_t;

  logic [15:0] mem [0:(1<<20)-1];
  txn_t        txn_log [$];
  int          mem_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [15:0] pat(input logic [19:0] a);
    return a[15:0] ^ 16'hC3C3;
  endfunction

  // SRAM controller model: ready pulses after RW_CYCLES cycles of valid.
  always @(negedge clk) begin
    if (rst) begin
      mem_to_cache = '0;
      mem_cnt      = 0;
    end else if (mem_to_cache.ready) begin
      mem_to_cache.ready = 1'b0;
      mem_cnt            = 0;
    end else if (cache_to_mem.valid) begin
      mem_cnt++;
      if (mem_cnt == RW_CYCLES) begin
        mem_to_cache.ready = 1'b1;
        if (cache_to_mem.rw) begin
          mem[cache_to_mem.addr] = cache_to_mem.data;
          mem_to_cache.data      = '0;
        end else begin
          mem_to_cache.data = mem[cache_to_mem.addr];
        end
        txn_log.push_back('{cache_to_mem.rw, cache_to_mem.addr, cache_to_mem.data});
      end
    end else begin
      mem_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_access(input logic rw, input logic [19:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output int lat);
    bit done;
    done  = 1'b0;
    lat   = 0;
    rdata = '0;
    @(negedge clk);
    cpu_req = '{valid: 1'b1, rw: rw, addr: addr, data: wdata};
    @(posedge clk);
    while (!done && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
      if (cpu_res.ready) begin
        done  = 1'b1;
        rdata = cpu_res.data;
      end
    end
    cpu_req.valid = 1'b0;
    if (!done) check("cpu ready timeout", {31'b0, cpu_res.ready}, 32'd1);
  endtask

  // One access with data/latency/traffic checks; exp_lat 0 skips the latency check.
  task automatic access_chk(input string tag, input logic rw, input logic [19:0] addr,
                            input logic [15:0] wdata, input logic [15:0] exp_data,
                            input int exp_lat, input int exp_txns);
    logic [15:0] rd;
    int lat, base;
    base = txn_log.size();
    cpu_access(rw, addr, wdata, rd, lat);
    if (!rw) check({tag, " data"}, 32'(rd), 32'(exp_data));
    if (exp_lat != 0) check({tag, " latency"}, lat, exp_lat);
    check({tag, " sram txns"}, txn_log.size() - base, exp_txns);
  endtask

  task automatic txn_chk(input string tag, input int k, input logic rw,
                         input logic [19:0] addr, input logic [15:0] data, input bit cmp_data);
    if (k >= txn_log.size()) begin
      check({tag, " missing"}, txn_log.size(), k + 1);
    end else begin
      check({tag, " rw"}, 32'(txn_log[k].rw), 32'(rw));
      check({tag, " addr"}, 32'(txn_log[k].addr), 32'(addr));
      if (cmp_data) check({tag, " data"}, 32'(txn_log[k].data), 32'(data));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  seen;
    cpu_req = '0;
    rst     = 1'b1;
    for (int i = 0; i < (1 << 20); i++) mem[i] = pat(20'(i));
    mem[20'h00005] = 16'hBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cpu ready", 32'(cpu_res.ready), 32'd0);
    check("reset cpu data", 32'(cpu_res.data), 32'd0);
    check("reset mem valid", 32'(cache_to_mem.valid), 32'd0);
    check("reset mem rw", 32'(cache_to_mem.rw), 32'd0);
    rst = 1'b0;

    // 1: cold read miss, then hit
    base = txn_log.size();
    access_chk("t1 miss", 1'b0, 20'h00005, 16'h0, 16'hBEEF, LAT_CLEAN, 1);
    txn_chk("t1 refill", base, 1'b0, 20'h00005, 16'h0, 1'b0);
    access_chk("t1 hit", 1'b0, 20'h00005, 16'h0, 16'hBEEF, LAT_HIT, 0);

    // 2: write hit stays in cache
    access_chk("t2 write hit", 1'b1, 20'h00005, 16'h1234, 16'h0, LAT_HIT, 0);
    access_chk("t2 read back", 1'b0, 20'h00005, 16'h0, 16'h1234, LAT_HIT, 0);
    check("t2 sram untouched", 32'(mem[20'h00005]), 32'hBEEF);

    // 3: fill set 5, then evict dirty 0x00005
    access_chk("t3 fill way1", 1'b0, 20'h00045, 16'h0, pat(20'h00045), LAT_CLEAN, 1);
    base = txn_log.size();
    access_chk("t3 dirty evict", 1'b0, 20'h00085, 16'h0, pat(20'h00085), 0, 2);
    txn_chk("t3 write-back", base, 1'b1, 20'h00005, 16'h1234, 1'b1);
    txn_chk("t3 refill", base + 1, 1'b0, 20'h00085, 16'h0, 1'b0);

    // 4: LRU picks the clean line holding 0x00085
    access_chk("t4 hit 45", 1'b0, 20'h00045, 16'h0, pat(20'h00045), LAT_HIT, 0);
    base = txn_log.size();
    access_chk("t4 miss c5", 1'b0, 20'h000C5, 16'h0, pat(20'h000C5), LAT_CLEAN, 1);
    txn_chk("t4 refill", base, 1'b0, 20'h000C5, 16'h0, 1'b0);
    access_chk("t4 45 kept", 1'b0, 20'h00045, 16'h0, pat(20'h00045), LAT_HIT, 0);

    // 5: write miss allocates, later evicted with its data
    base = txn_log.size();
    access_chk("t5 write miss", 1'b1, 20'h00106, 16'hA5A5, 16'h0, LAT_CLEAN, 1);
    txn_chk("t5 refill", base, 1'b0, 20'h00106, 16'h0, 1'b0);
    access_chk("t5 read merged", 1'b0, 20'h00106, 16'h0, 16'hA5A5, LAT_HIT, 0);
    access_chk("t5 fill way1", 1'b0, 20'h00146, 16'h0, pat(20'h00146), LAT_CLEAN, 1);
    base = txn_log.size();
    access_chk("t5 dirty evict", 1'b0, 20'h00186, 16'h0, pat(20'h00186), 0, 2);
    txn_chk("t5 write-back", base, 1'b1, 20'h00106, 16'hA5A5, 1'b1);
    txn_chk("t5 refill 186", base + 1, 1'b0, 20'h00186, 16'h0, 1'b0);
    check("t5 sram data", 32'(mem[20'h00106]), 32'hA5A5);

    // 6: reset during write-back discards the dirty line
    access_chk("t6 write miss", 1'b1, 20'h00005, 16'h7777, 16'h0, LAT_CLEAN, 1);
    access_chk("t6 touch 45", 1'b0, 20'h00045, 16'h0, pat(20'h00045), LAT_HIT, 0);
    @(negedge clk);
    cpu_req = '{valid: 1'b1, rw: 1'b0, addr: 20'h00085, data: 16'h0};
    seen = 1'b0;
    for (int i = 0; i < MAX_WAIT && !seen; i++) begin
      @(negedge clk);
      if (cache_to_mem.valid && cache_to_mem.rw) seen = 1'b1;
    end
    check("t6 reached write-back", 32'(seen), 32'd1);
    check("t6 write-back addr", 32'(cache_to_mem.addr), 32'h00005);
    rst = 1'b1;
    cpu_req.valid = 1'b0;
    @(negedge clk);
    check("t6 mem valid after rst", 32'(cache_to_mem.valid), 32'd0);
    check("t6 cpu ready after rst", 32'(cpu_res.ready), 32'd0);
    rst = 1'b0;
    check("t6 sram kept old", 32'(mem[20'h00005]), 32'h1234);
    access_chk("t6 reread misses", 1'b0, 20'h00005, 16'h0, 16'h1234, LAT_CLEAN, 1);
    access_chk("t6 45 invalidated", 1'b0, 20'h00045, 16'h0, pat(20'h00045), LAT_CLEAN, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
